ram_io_responder: RTL and testbench
===================================

# ram_io_responder

Memory-side responder for the CPU's byte-wide memory bus: services instruction/data reads and writes against a 128 KB RAM, and decodes the I/O window at `mem_a[17:16]==2'b11` (UART byte in/out, cycle counter, program stop). Sits opposite the CPU's memory controller at the top level, and drives the CPU's `rdy_in` so the core pauses when the UART transmit buffer is close to full.

## Interface
- `RAM_ADDR_WIDTH`, default 17: RAM byte-address width (128 KB).
- `TX_FIFO_AW`, default 4: log2 of the transmit FIFO depth (default depth 16).

- `clk_in` in 1: system clock.
- `rst_in` in 1: synchronous reset, active-low.
- `mem_a` in 32: byte address from the CPU; only bits [17:0] are decoded.
- `mem_dout` in 8: write data from the CPU.
- `mem_wr` in 1: 1 = write, 0 = read.
- `mem_din` out 8: read data to the CPU.
- `cpu_rdy` out 1: connects to the CPU's `rdy_in`; low means the CPU pauses.
- `rx_data` in 8: UART receive byte.
- `rx_valid` in 1: `rx_data` holds a byte.
- `rx_ready` out 1: one-cycle pop strobe to the UART receiver.
- `tx_data` out 8: transmit FIFO head.
- `tx_valid` out 1: transmit FIFO is not empty.
- `tx_ready` in 1: UART transmitter accepts `tx_data`.
- `prog_done` out 1: stop has been written and the transmit FIFO has drained.
- `tx_overflow` out 1: sticky; a transmit byte was dropped because the FIFO was full.

## Operation
- **Address decode** on `mem_a[17:16]`:
  - `00`/`01`: RAM at `mem_a[16:0]`.
  - `10`: unmapped; reads return 0x00, writes are ignored.
  - `11`: I/O, decoded on `mem_a[2:0]`.
- **RAM**
  - Write commits at the posedge where `mem_wr=1`.
  - Read is registered. RAM contents are not reset.
- **I/O reads**
  - 0x30000: returns `rx_data` if `rx_valid`, else 0x00. Pops (`rx_ready` high one cycle) only on the first cycle of a run of consecutive 0x30000 reads. A run ends on any cycle with a different address or with `mem_wr=1`.
  - 0x30004: snapshots the 32-bit cycle counter into `cnt_latch` and returns byte 0.
  - 0x30005–0x30007: return `cnt_latch` bytes 1–3, little-endian.
  - Any other I/O address reads 0x00.
- **I/O writes**
  - 0x30000 with a nonzero byte: pushes the byte to the TX FIFO. A 0x00 byte is ignored.
  - 0x30004: sets the sticky `stop_flag` and pushes 0x00 to the TX FIFO.
  - Any other I/O address: write is ignored.
- **TX FIFO**
  - Circular buffer with read/write pointers and an occupancy count that is one bit wider than `TX_FIFO_AW`.
  - Pop when `tx_valid && tx_ready`.
  - Simultaneous push and pop: count unchanged, both pointers advance. Allowed when full, because the pop frees a slot.
  - Push when full without a pop: byte is dropped and `tx_overflow` is set.
- **Cycle counter**: 32-bit, free-running, +1 every cycle after reset, wraps 0xFFFFFFFF → 0.
- **`cpu_rdy`**: registered; equals `next_count <= DEPTH-2`. This leaves one slot for a write already on the bus.
- **`prog_done`**: registered; `stop_flag && count==0`, and stays high once set.

## Timing
- **Reset values**: `mem_din`=0x00, `cpu_rdy`=1, `rx_ready`=0, `tx_valid`=0, `tx_data`=0x00, `prog_done`=0, `tx_overflow`=0. Also cleared on reset: counter=0, `cnt_latch`=0, `stop_flag`=0, FIFO empty, run-tracking cleared.
- **Read latency**: address sampled at edge N; `mem_din` valid after edge N+1. Each cycle's address produces data exactly one cycle later, so back-to-back reads pipeline.
- **Write latency**: takes effect at edge N. A read of the same RAM address sampled at edge N+1 returns the new data.
- **Same-edge read and write**: for the same RAM address the two cannot coincide (single bus).
- **`rx_ready`**: asserted in the cycle after the sampling edge. `rx_data` is captured at the sampling edge.
- **Counter snapshot**: the 0x30004 snapshot is taken at the sampling edge, so it holds the pre-increment counter value of that edge.
- **Reset mid-operation**: a pending read is discarded, FIFO contents are lost, and `mem_din` returns to 0x00 the cycle after reset.
- **`tx_valid`/`tx_data`**: follow the FIFO head combinationally from registered pointers.

## Configuration
- **`RAM_IO_CYCLE_COUNTER_EN`**
  - Defined: the counter, `cnt_latch` and reads of 0x30004–0x30007 behave as above.
  - Undefined: counter and latch are not built; reads of 0x30004–0x30007 return 0x00. Stop writes to 0x30004 are unaffected.

## Test plan
- **RAM read-after-write**: write 0xA5 to 0x00123, then read 0x00123 → `mem_din`=0xA5 one cycle after the read address; 0x1FFFF round-trips; read of 0x20000 → 0x00.
- **UART out, FIFO full**: write 'H', 0x00, 'i' to 0x30000 with `tx_ready`=1 → `tx_data` sequence 0x48, 0x69 only. With `tx_ready`=0, write 15 bytes → `cpu_rdy` low from the edge where count reaches 15; a 17th push sets `tx_overflow`.
- **UART in**: `rx_valid`=1, `rx_data`=0x37, read 0x30000 for three consecutive cycles → `mem_din`=0x37 and exactly one `rx_ready` pulse. A read with `rx_valid`=0 → 0x00.
- **Counter**: after 1000 cycles of reset-free run, read 0x30004–0x30007 → little-endian 32-bit value 999 ± pipeline offset, consistent across the four bytes. Built without the macro → all 0x00.
- **Stop**: write 0x30004 with 3 bytes queued and `tx_ready`=1 → 0x00 appears as the fourth TX byte and `prog_done` rises one cycle after the FIFO empties.
- **Reset**: assert `rst_in`=0 mid-burst → all outputs at reset values at the next edge and the FIFO is empty.

Source files
------------

// File: rtl/ram_io_responder.sv
// Byte-wide memory responder: 128 KB RAM, UART in/out window, stop register and TX FIFO.
// Optional: define RAM_IO_CYCLE_COUNTER_EN to build the cycle counter readable at 0x30004-0x30007.
module ram_io_responder #(
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned TX_FIFO_AW     = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        cpu_rdy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_done,
  output logic        tx_overflow
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int unsigned TX_DEPTH  = 1 << TX_FIFO_AW;
  localparam int unsigned CNT_W     = TX_FIFO_AW + 1;

  typedef enum logic [1:0] {RD_ZERO, RD_RAM, RD_RX, RD_CNT} rd_sel_e;

  // Address decode
  logic                      is_ram_c;
  logic                      is_io_c;
  logic [2:0]                io_off_c;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_c;
  logic                      unused_addr_bits;

  assign is_ram_c         = ~mem_a[17];
  assign is_io_c          = (mem_a[17:16] == 2'b11);
  assign io_off_c         = mem_a[2:0];
  assign ram_addr_c       = mem_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^mem_a[31:18];

  // RAM array and its read register; contents are never reset
  logic [7:0] ram_q [RAM_DEPTH];
  logic [7:0] ram_rd_q;

  always_ff @(posedge clk_in) begin
    if (mem_wr && is_ram_c) ram_q[ram_addr_c] <= mem_dout;
    ram_rd_q <= ram_q[ram_addr_c];
  end

  // First read stage: what to return, plus the side effects taken at the sampling edge
  rd_sel_e    rd_sel_d, rd_sel_q;
  logic [7:0] rx_byte_q;
  logic       rx_rd_c;
  logic       rx_pop_c;
  logic       rx_run_q;
  logic       rx_ready_q;

  assign rx_rd_c  = ~mem_wr && is_io_c && (io_off_c == 3'd0);
  assign rx_pop_c = rx_rd_c && ~rx_run_q && rx_valid;

  always_comb begin
    rd_sel_d = RD_ZERO;
    if (!mem_wr) begin
      if (is_ram_c) begin
        rd_sel_d = RD_RAM;
      end else if (is_io_c) begin
        if (io_off_c == 3'd0) rd_sel_d = RD_RX;
`ifdef RAM_IO_CYCLE_COUNTER_EN
        else if (io_off_c[2]) rd_sel_d = RD_CNT;
`endif
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_sel_q   <= RD_ZERO;
      rx_byte_q  <= 8'h00;
      rx_run_q   <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      rd_sel_q   <= rd_sel_d;
      rx_byte_q  <= rx_valid ? rx_data : 8'h00;
      rx_run_q   <= rx_rd_c;
      rx_ready_q <= rx_pop_c;
    end
  end

`ifdef RAM_IO_CYCLE_COUNTER_EN
  // Free-running counter; the latch holds the value present at the 0x30004 sampling edge
  logic [31:0] cnt_q;
  logic [31:0] cnt_latch_q;
  logic [1:0]  rd_byte_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q       <= 32'h0;
      cnt_latch_q <= 32'h0;
      rd_byte_q   <= 2'd0;
    end else begin
      cnt_q     <= cnt_q + 32'd1;
      rd_byte_q <= mem_a[1:0];
      if (!mem_wr && is_io_c && (io_off_c == 3'd4)) cnt_latch_q <= cnt_q;
    end
  end
`endif

  // Second read stage: registered read data
  logic [7:0] mem_din_d, mem_din_q;

  always_comb begin
    mem_din_d = 8'h00;
    case (rd_sel_q)
      RD_RAM:  mem_din_d = ram_rd_q;
      RD_RX:   mem_din_d = rx_byte_q;
`ifdef RAM_IO_CYCLE_COUNTER_EN
      RD_CNT:  mem_din_d = cnt_latch_q[{rd_byte_q, 3'b000} +: 8];
`endif
      default: mem_din_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) mem_din_q <= 8'h00;
    else         mem_din_q <= mem_din_d;
  end

  // Transmit FIFO
  logic [7:0]            fifo_q [TX_DEPTH];
  logic [TX_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  stop_wr_c;
  logic                  push_req_c;
  logic [7:0]            push_byte_c;
  logic                  full_c;
  logic                  tx_pop_c;
  logic                  push_ok_c;
  logic                  overflow_c;

  assign stop_wr_c   = mem_wr && is_io_c && (io_off_c == 3'd4);
  assign push_req_c  = stop_wr_c ||
                       (mem_wr && is_io_c && (io_off_c == 3'd0) && (mem_dout != 8'h00));
  assign push_byte_c = stop_wr_c ? 8'h00 : mem_dout;
  assign full_c      = (count_q == CNT_W'(TX_DEPTH));
  assign tx_pop_c    = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok_c   = push_req_c && (~full_c || tx_pop_c);
  assign overflow_c  = push_req_c && full_c && ~tx_pop_c;
  assign count_d     = count_q + CNT_W'(push_ok_c) - CNT_W'(tx_pop_c);

  always_ff @(posedge clk_in) begin
    if (push_ok_c) fifo_q[wr_ptr_q] <= push_byte_c;
  end

  logic stop_flag_q;
  logic tx_overflow_q;
  logic cpu_rdy_q;
  logic prog_done_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      stop_flag_q   <= 1'b0;
      tx_overflow_q <= 1'b0;
      cpu_rdy_q     <= 1'b1;
      prog_done_q   <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + TX_FIFO_AW'(1);
      if (tx_pop_c)  rd_ptr_q <= rd_ptr_q + TX_FIFO_AW'(1);
      count_q       <= count_d;
      stop_flag_q   <= stop_flag_q | stop_wr_c;
      tx_overflow_q <= tx_overflow_q | overflow_c;
      // Keep one slot free for a write already on the bus when the core stalls
      cpu_rdy_q     <= (count_d <= CNT_W'(TX_DEPTH - 2));
      prog_done_q   <= prog_done_q | (stop_flag_q && (count_q == '0));
    end
  end

  assign mem_din     = mem_din_q;
  assign rx_ready    = rx_ready_q;
  assign cpu_rdy     = cpu_rdy_q;
  assign prog_done   = prog_done_q;
  assign tx_overflow = tx_overflow_q;
  assign tx_valid    = (count_q != '0);
  assign tx_data     = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder (RAM, UART in/out, counter, stop, reset).
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        cpu_rdy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prog_done;
  logic        tx_overflow;

  ram_io_responder dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .mem_a      (mem_a),
    .mem_dout   (mem_dout),
    .mem_wr     (mem_wr),
    .mem_din    (mem_din),
    .cpu_rdy    (cpu_rdy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .prog_done  (prog_done),
    .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] tb_cyc;
  logic [7:0]  tx_log[$];

  // Reference cycle count and log of every byte the UART transmitter accepts
  always @(posedge clk_in) begin
    if (!rst_in) tb_cyc <= 32'h0;
    else         tb_cyc <= tb_cyc + 32'd1;
    if (rst_in && tx_valid && tx_ready) tx_log.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    mem_a    = 32'h0002_0000;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
    mem_a    = addr;
    mem_dout = data;
    mem_wr   = 1'b1;
    tick();
    drive_idle();
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [7:0] d);
    mem_a  = addr;
    mem_wr = 1'b0;
    tick();
    drive_idle();
    tick();
    d = mem_din;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_din"},     32'(mem_din),     32'h00);
    check({pfx, "_cpu_rdy"},     32'(cpu_rdy),     32'h1);
    check({pfx, "_rx_ready"},    32'(rx_ready),    32'h0);
    check({pfx, "_tx_valid"},    32'(tx_valid),    32'h0);
    check({pfx, "_tx_data"},     32'(tx_data),     32'h00);
    check({pfx, "_prog_done"},   32'(prog_done),   32'h0);
    check({pfx, "_tx_overflow"}, 32'(tx_overflow), 32'h0);
  endtask

  initial begin
    logic [7:0]  d;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_cnt;
    int          pulses;
    int          base;

    rst_in   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    drive_idle();
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_in = 1'b1;
    tick();

    // RAM read-after-write, top address, unmapped window
    bus_write(32'h0000_0123, 8'hA5);
    bus_read(32'h0000_0123, d);
    check("ram_raw_123", 32'(d), 32'hA5);
    bus_write(32'h0001_FFFF, 8'h5A);
    bus_read(32'h0001_FFFF, d);
    check("ram_1ffff", 32'(d), 32'h5A);
    bus_write(32'h0002_0000, 8'h77);
    bus_read(32'h0002_0000, d);
    check("unmapped_rd", 32'(d), 32'h00);

    // Back-to-back reads pipeline one per cycle
    mem_a = 32'h0000_0123;
    tick();
    mem_a = 32'h0001_FFFF;
    tick();
    check("pipe_rd0", 32'(mem_din), 32'hA5);
    drive_idle();
    tick();
    check("pipe_rd1", 32'(mem_din), 32'h5A);

    // UART out: zero byte is swallowed
    tx_ready = 1'b1;
    base = tx_log.size();
    bus_write(32'h0003_0000, 8'h48);
    bus_write(32'h0003_0000, 8'h00);
    bus_write(32'h0003_0000, 8'h69);
    repeat (3) tick();
    check("tx_hi_len", 32'(tx_log.size() - base), 32'd2);
    if (tx_log.size() - base == 2) begin
      check("tx_hi_0", 32'(tx_log[base]),     32'h48);
      check("tx_hi_1", 32'(tx_log[base + 1]), 32'h69);
    end

    // FIFO fill: stall at 15 entries, drop on the 17th push
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus_write(32'h0003_0000, 8'(i + 1));
      if (i == 13) check("rdy_at_14", 32'(cpu_rdy), 32'h1);
      if (i == 14) check("rdy_at_15", 32'(cpu_rdy), 32'h0);
      if (i == 15) check("ovf_at_16", 32'(tx_overflow), 32'h0);
      if (i == 16) check("ovf_at_17", 32'(tx_overflow), 32'h1);
    end
    base = tx_log.size();
    tx_ready = 1'b1;
    repeat (20) tick();
    check("drain_len", 32'(tx_log.size() - base), 32'd16);
    if (tx_log.size() - base == 16) begin
      check("drain_first", 32'(tx_log[base]),      32'h01);
      check("drain_last",  32'(tx_log[base + 15]), 32'h10);
    end
    check("rdy_after_drain", 32'(cpu_rdy), 32'h1);

    // UART in: three-cycle run gives one pop
    rx_data  = 8'h37;
    rx_valid = 1'b1;
    pulses   = 0;
    b0       = 8'h00;
    mem_a    = 32'h0003_0000;
    mem_wr   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rx_ready) pulses++;
      if (k == 1) b0 = mem_din;
    end
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rx_ready) pulses++;
    end
    check("rx_data", 32'(b0), 32'h37);
    check("rx_pulses", 32'(pulses), 32'd1);
    rx_valid = 1'b0;
    bus_read(32'h0003_0000, d);
    check("rx_empty", 32'(d), 32'h00);

    // Cycle counter snapshot read back byte by byte
    repeat (1000) tick();
    mem_a   = 32'h0003_0004;
    mem_wr  = 1'b0;
    exp_cnt = tb_cyc;
    tick();
    mem_a = 32'h0003_0005;
    tick();
    b0    = mem_din;
    mem_a = 32'h0003_0006;
    tick();
    b1    = mem_din;
    mem_a = 32'h0003_0007;
    tick();
    b2 = mem_din;
    drive_idle();
    tick();
    b3 = mem_din;
`ifndef RAM_IO_CYCLE_COUNTER_EN
    exp_cnt = 32'h0;
`endif
    check("cnt_b0", 32'(b0), 32'(exp_cnt[7:0]));
    check("cnt_b1", 32'(b1), 32'(exp_cnt[15:8]));
    check("cnt_b2", 32'(b2), 32'(exp_cnt[23:16]));
    check("cnt_b3", 32'(b3), 32'(exp_cnt[31:24]));

    // Stop with three bytes queued
    tx_ready = 1'b0;
    bus_write(32'h0003_0000, 8'h11);
    bus_write(32'h0003_0000, 8'h22);
    bus_write(32'h0003_0000, 8'h33);
    bus_write(32'h0003_0004, 8'hFF);
    check("done_while_queued", 32'(prog_done), 32'h0);
    base = tx_log.size();
    tx_ready = 1'b1;
    for (int k = 0; k < 40 && tx_valid; k++) tick();
    check("stop_drained", 32'(tx_valid), 32'h0);
    check("done_on_empty_edge", 32'(prog_done), 32'h0);
    tick();
    check("done_next_cycle", 32'(prog_done), 32'h1);
    check("stop_len", 32'(tx_log.size() - base), 32'd4);
    if (tx_log.size() - base == 4) begin
      check("stop_b2", 32'(tx_log[base + 2]), 32'h33);
      check("stop_b3", 32'(tx_log[base + 3]), 32'h00);
    end
    repeat (3) tick();
    check("done_sticky", 32'(prog_done), 32'h1);

    // Reset in the middle of a burst with a read in flight
    tx_ready = 1'b0;
    bus_write(32'h0003_0000, 8'h01);
    bus_write(32'h0003_0000, 8'h02);
    bus_write(32'h0003_0000, 8'h03);
    mem_a = 32'h0000_0123;
    tick();
    rst_in = 1'b0;
    drive_idle();
    tick();
    check_reset_outputs("mid_rst");
    rst_in = 1'b1;
    tick();
    check("post_rst_empty", 32'(tx_valid), 32'h0);
    check("post_rst_din", 32'(mem_din), 32'h00);
    bus_read(32'h0000_0123, d);
    check("ram_kept", 32'(d), 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
